romulus_sequencer: RTL and testbench

- Control-side counterpart of the Romulus datapath.
- Accepts one operation command from the host-side controller and performs host handshakes on the sdi, pdi and pdo buses.
- Drives every datapath strobe in the correct order: state/counter clear, key load, tweak load, message absorb/emit, TBC rounds with round constants, and tweakey correction.
- Consumes no datapath data; it only generates the strobes and the constant/decrypt/domain side-band.

---
 rtl/romulus_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_romulus_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/romulus_sequencer.sv
// romulus_sequencer: control FSM for the Romulus datapath. One command per start;
// walks CLR -> KEY -> TWEAK -> MSG (enabled phases only) -> TBC -> CORR -> DONE.
// Ports: start/op_* command (sampled in IDLE), sdi/pdi/pdo handshakes, busy/done status,
//        s/x/y/z register strobes, correct_cnt, round constant, per-byte decrypt, domain.
// Strobes are combinational from state (plus handshake inputs); nothing is registered on
// the way out except domain.
module romulus_sequencer #(
  parameter int BUSWIDTH   = 32,
  parameter int ROUNDS     = 40,
  parameter int CONSTWIDTH = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    op_clr,
  input  logic                    op_key,
  input  logic                    op_tweak,
  input  logic                    op_msg,
  input  logic                    op_emit,
  input  logic                    op_dec,
  input  logic                    op_incr,
  input  logic [7:0]              domain_i,
  input  logic                    sdi_valid,
  output logic                    sdi_ready,
  input  logic                    pdi_valid,
  output logic                    pdi_ready,
  output logic                    pdo_valid,
  input  logic                    pdo_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    srst,
  output logic                    sen,
  output logic                    senc,
  output logic                    xrst,
  output logic                    xen,
  output logic                    xenc,
  output logic                    yrst,
  output logic                    yen,
  output logic                    yenc,
  output logic                    zrst,
  output logic                    zen,
  output logic                    zenc,
  output logic                    erst,
  output logic                    tk1s,
  output logic                    correct_cnt,
  output logic [CONSTWIDTH-1:0]   constant,
  output logic [BUSWIDTH/8-1:0]   decrypt,
  output logic [7:0]              domain
);

  localparam int WORDS = 128 / BUSWIDTH;
  localparam int WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int RCW   = $clog2(ROUNDS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_KEY, S_TWEAK, S_MSG, S_TBC, S_CORR, S_DONE
  } state_t;

  state_t         state, state_d;
  logic           f_clr, f_key, f_tweak, f_msg, f_emit, f_dec, f_incr;
  logic [7:0]     domain_q;
  logic [WCW-1:0] wcnt;
  logic [RCW-1:0] rnd;
  logic [5:0]     rc;
  logic [5:0]     rc_upd;
  logic           accept;
  logic           last_word;
  logic           last_round;

  // First enabled phase strictly after 'cur' in CLR, KEY, TWEAK, MSG order;
  // TBC when nothing further is enabled. Enum order matches the phase order.
  function automatic state_t next_phase(input state_t cur, input logic c, input logic k,
                                        input logic t, input logic m);
    next_phase = S_TBC;
    if (m && cur < S_MSG)   next_phase = S_MSG;
    if (t && cur < S_TWEAK) next_phase = S_TWEAK;
    if (k && cur < S_KEY)   next_phase = S_KEY;
    if (c && cur < S_CLR)   next_phase = S_CLR;
  endfunction

  assign rc_upd     = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  assign last_word  = (wcnt == WCW'(WORDS - 1));
  assign last_round = (rnd == RCW'(ROUNDS - 1));
  assign domain     = domain_q;
  assign erst       = 1'b0;
  assign tk1s       = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      f_clr    <= 1'b0;
      f_key    <= 1'b0;
      f_tweak  <= 1'b0;
      f_msg    <= 1'b0;
      f_emit   <= 1'b0;
      f_dec    <= 1'b0;
      f_incr   <= 1'b0;
      domain_q <= 8'h00;
      wcnt     <= '0;
      rnd      <= '0;
      rc       <= '0;
    end else begin
      state <= state_d;
      if (state == S_IDLE && start) begin
        f_clr    <= op_clr;
        f_key    <= op_key;
        f_tweak  <= op_tweak;
        f_msg    <= op_msg;
        f_emit   <= op_emit;
        f_dec    <= op_dec;
        f_incr   <= op_incr;
        domain_q <= domain_i;
      end
      // Counter restarts on every phase change, so each phase sees it at 0.
      if (state_d != state)
        wcnt <= '0;
      else if (accept)
        wcnt <= wcnt + 1'b1;
      // Round index and rc sit at 0 outside TBC, so entry always starts clean.
      if (state == S_TBC) begin
        rnd <= rnd + 1'b1;
        rc  <= rc_upd;
      end else begin
        rnd <= '0;
        rc  <= '0;
      end
    end
  end

  always_comb begin
    state_d     = state;
    accept      = 1'b0;
    sdi_ready   = 1'b0;
    pdi_ready   = 1'b0;
    pdo_valid   = 1'b0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    srst        = 1'b0;
    sen         = 1'b0;
    senc        = 1'b0;
    xrst        = 1'b0;
    xen         = 1'b0;
    xenc        = 1'b0;
    yrst        = 1'b0;
    yen         = 1'b0;
    yenc        = 1'b0;
    zrst        = 1'b0;
    zen         = 1'b0;
    zenc        = 1'b0;
    correct_cnt = 1'b0;
    constant    = '0;
    decrypt     = '0;

    unique case (state)
      S_IDLE: begin
        if (start) state_d = next_phase(S_IDLE, op_clr, op_key, op_tweak, op_msg);
      end
      S_CLR: begin
        srst    = 1'b1;
        zrst    = 1'b1;
        state_d = next_phase(S_CLR, f_clr, f_key, f_tweak, f_msg);
      end
      S_KEY: begin
        sdi_ready = 1'b1;
        xrst      = sdi_valid;
        accept    = sdi_valid;
      end
      S_TWEAK: begin
        pdi_ready = 1'b1;
        yrst      = pdi_valid;
        accept    = pdi_valid;
      end
      S_MSG: begin
        // With emit, input is only taken when the output side can take the
        // matching word; pdo_valid never looks at pdo_ready.
        pdi_ready = f_emit ? pdo_ready : 1'b1;
        pdo_valid = f_emit & pdi_valid;
        accept    = pdi_valid & pdi_ready;
        sen       = accept;
        decrypt   = f_dec ? '1 : '0;
      end
      S_TBC: begin
        sen      = 1'b1;
        senc     = 1'b1;
        xen      = 1'b1;
        xenc     = 1'b1;
        yen      = 1'b1;
        yenc     = 1'b1;
        zen      = 1'b1;
        zenc     = 1'b1;
        constant = CONSTWIDTH'(rc_upd);
        if (last_round) state_d = S_CORR;
      end
      S_CORR: begin
        xen         = 1'b1;
        yen         = 1'b1;
        zen         = 1'b1;
        correct_cnt = f_incr;
        state_d     = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state == S_KEY || state == S_TWEAK || state == S_MSG) && accept && last_word)
      state_d = next_phase(state, f_clr, f_key, f_tweak, f_msg);
  end

endmodule

// File: tb/tb_romulus_sequencer.sv
module tb_romulus_sequencer;
  localparam int BW = 32;
  localparam int ROUNDS = 40;
  localparam int CW = 12;
  localparam int WORDS = 128 / BW;
  localparam int DW = BW / 8;
  localparam int AW = 20 + CW + DW + 8;
  localparam int P_IDLE = 0, P_CLR = 1, P_KEY = 2, P_TWEAK = 3, P_MSG = 4,
                 P_TBC = 5, P_CORR = 6, P_DONE = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, op_clr, op_key, op_tweak, op_msg, op_emit, op_dec, op_incr;
  logic [7:0] domain_i;
  logic sdi_valid, pdi_valid, pdo_ready;
  logic sdi_ready, pdi_ready, pdo_valid, busy, done;
  logic srst, sen, senc, xrst, xen, xenc, yrst, yen, yenc, zrst, zen, zenc, erst, tk1s, correct_cnt;
  logic [CW-1:0] constant;
  logic [DW-1:0] decrypt;
  logic [7:0] domain;

  romulus_sequencer #(.BUSWIDTH(BW), .ROUNDS(ROUNDS), .CONSTWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .op_clr(op_clr), .op_key(op_key), .op_tweak(op_tweak),
    .op_msg(op_msg), .op_emit(op_emit), .op_dec(op_dec), .op_incr(op_incr), .domain_i(domain_i),
    .sdi_valid(sdi_valid), .sdi_ready(sdi_ready), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
    .pdo_valid(pdo_valid), .pdo_ready(pdo_ready), .busy(busy), .done(done),
    .srst(srst), .sen(sen), .senc(senc), .xrst(xrst), .xen(xen), .xenc(xenc),
    .yrst(yrst), .yen(yen), .yenc(yenc), .zrst(zrst), .zen(zen), .zenc(zenc),
    .erst(erst), .tk1s(tk1s), .correct_cnt(correct_cnt), .constant(constant),
    .decrypt(decrypt), .domain(domain));

  // Second instance at 64-bit bus width for the per-byte decrypt check.
  logic b_start;
  logic b_sdi_ready, b_pdi_ready, b_pdo_valid, b_busy, b_done;
  logic b_srst, b_sen, b_senc, b_xrst, b_xen, b_xenc, b_yrst, b_yen, b_yenc;
  logic b_zrst, b_zen, b_zenc, b_erst, b_tk1s, b_correct_cnt;
  logic [CW-1:0] b_constant;
  logic [7:0] b_decrypt;
  logic [7:0] b_domain;

  romulus_sequencer #(.BUSWIDTH(64), .ROUNDS(ROUNDS), .CONSTWIDTH(CW)) dut64 (
    .clk(clk), .rst(rst), .start(b_start), .op_clr(op_clr), .op_key(op_key), .op_tweak(op_tweak),
    .op_msg(op_msg), .op_emit(op_emit), .op_dec(op_dec), .op_incr(op_incr), .domain_i(domain_i),
    .sdi_valid(sdi_valid), .sdi_ready(b_sdi_ready), .pdi_valid(pdi_valid), .pdi_ready(b_pdi_ready),
    .pdo_valid(b_pdo_valid), .pdo_ready(pdo_ready), .busy(b_busy), .done(b_done),
    .srst(b_srst), .sen(b_sen), .senc(b_senc), .xrst(b_xrst), .xen(b_xen), .xenc(b_xenc),
    .yrst(b_yrst), .yen(b_yen), .yenc(b_yenc), .zrst(b_zrst), .zen(b_zen), .zenc(b_zenc),
    .erst(b_erst), .tk1s(b_tk1s), .correct_cnt(b_correct_cnt), .constant(b_constant),
    .decrypt(b_decrypt), .domain(b_domain));

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // ---------------- behavioural model ----------------
  int m_phase, m_words, m_round;
  logic [3:0] m_todo;       // remaining pre-TBC phases: bit0 clr, bit1 key, bit2 tweak, bit3 msg
  logic m_emit, m_dec, m_incr;
  logic [7:0] m_dom;
  logic m_acc;

  function automatic int first_of(input logic [3:0] t);
    for (int i = 0; i < 4; i++) if (t[i]) return i + 1;
    return P_TBC;
  endfunction

  function automatic logic [3:0] drop_first(input logic [3:0] t);
    logic [3:0] r;
    r = t;
    for (int i = 0; i < 4; i++) if (r[i]) begin r[i] = 1'b0; return r; end
    return r;
  endfunction

  // Round constant for round r: the 6-bit sequence stepped r+1 times from zero.
  function automatic logic [5:0] rc_of(input int r);
    logic [5:0] v;
    v = 6'd0;
    for (int i = 0; i <= r; i++) v = {v[4:0], v[5] ^ v[4] ^ 1'b1};
    return v;
  endfunction

  logic e_sdi_ready, e_pdi_ready, e_pdo_valid, e_sen, e_tbc, e_corr;
  logic [CW-1:0] e_const;
  logic [DW-1:0] e_dec;

  always_comb begin
    e_sdi_ready = 1'b0;
    e_pdi_ready = 1'b0;
    e_pdo_valid = 1'b0;
    e_sen = 1'b0;
    e_tbc = (m_phase == P_TBC);
    e_corr = (m_phase == P_CORR);
    e_const = '0;
    e_dec = '0;
    m_acc = 1'b0;
    if (m_phase == P_KEY) begin e_sdi_ready = 1'b1; m_acc = sdi_valid; end
    if (m_phase == P_TWEAK) begin e_pdi_ready = 1'b1; m_acc = pdi_valid; end
    if (m_phase == P_MSG) begin
      e_pdi_ready = m_emit ? pdo_ready : 1'b1;
      e_pdo_valid = m_emit & pdi_valid;
      m_acc = pdi_valid & e_pdi_ready;
      e_sen = m_acc;
      e_dec = m_dec ? '1 : '0;
    end
    if (e_tbc) begin e_sen = 1'b1; e_const = CW'(rc_of(m_round)); end
  end

  wire [AW-1:0] exp_vec = {e_sdi_ready, e_pdi_ready, e_pdo_valid, m_phase != P_IDLE, m_phase == P_DONE,
                           m_phase == P_CLR, e_sen, e_tbc,
                           m_phase == P_KEY && sdi_valid, e_tbc | e_corr, e_tbc,
                           m_phase == P_TWEAK && pdi_valid, e_tbc | e_corr, e_tbc,
                           m_phase == P_CLR, e_tbc | e_corr, e_tbc,
                           1'b0, 1'b0, e_corr & m_incr, e_const, e_dec, m_dom};
  wire [AW-1:0] act_vec = {sdi_ready, pdi_ready, pdo_valid, busy, done, srst, sen, senc,
                           xrst, xen, xenc, yrst, yen, yenc, zrst, zen, zenc,
                           erst, tk1s, correct_cnt, constant, decrypt, domain};

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= P_IDLE; m_todo <= 4'd0; m_words <= 0; m_round <= 0;
      m_emit <= 1'b0; m_dec <= 1'b0; m_incr <= 1'b0; m_dom <= 8'd0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin
          m_phase <= first_of({op_msg, op_tweak, op_key, op_clr});
          m_todo <= drop_first({op_msg, op_tweak, op_key, op_clr});
          m_words <= 0; m_round <= 0;
          m_emit <= op_emit; m_dec <= op_dec; m_incr <= op_incr; m_dom <= domain_i;
        end
        P_CLR: begin
          m_phase <= first_of(m_todo); m_todo <= drop_first(m_todo); m_words <= 0;
        end
        P_KEY, P_TWEAK, P_MSG: if (m_acc) begin
          if (m_words == WORDS - 1) begin
            m_phase <= first_of(m_todo); m_todo <= drop_first(m_todo); m_words <= 0;
          end else m_words <= m_words + 1;
        end
        P_TBC: if (m_round == ROUNDS - 1) begin m_phase <= P_CORR; m_round <= 0; end
               else m_round <= m_round + 1;
        P_CORR: m_phase <= P_DONE;
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (act_vec !== exp_vec) begin
        n_bad++;
        $display("FAIL model_vs_dut t=%0t phase=%0d actual=%h required=%h", $time, m_phase, act_vec, exp_vec);
      end
    end
  end

  // ---------------- directed helpers ----------------
  logic [12:0] tr[0:127];
  logic [CW-1:0] ctr[0:127];
  logic [7:0] dtr[0:127];
  logic [AW-1:0] atr[0:127];
  logic [3:0] btr[0:127];

  task automatic check(input string nm, input longint a, input longint e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  function automatic int cnt(input int b, input int lo, input int hi);
    int n;
    n = 0;
    for (int c = lo; c <= hi; c++) if (tr[c][b]) n++;
    return n;
  endfunction

  function automatic int first(input int b);
    for (int c = 1; c < 128; c++) if (tr[c][b]) return c;
    return -1;
  endfunction

  function automatic int bcnt(input int b);
    int n;
    n = 0;
    for (int c = 1; c < 128; c++) if (btr[c][b]) n++;
    return n;
  endfunction

  task automatic issue(input logic [6:0] f, input logic [7:0] dom, input bit to_b);
    {op_incr, op_dec, op_emit, op_msg, op_tweak, op_key, op_clr} = f;
    domain_i = dom;
    if (to_b) b_start = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; b_start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the start edge.
  task automatic capture(input int n, input int st_lo, input int st_hi, input int restart_at, input int rst_at);
    for (int c = 0; c < 128; c++) begin
      tr[c] = '0; ctr[c] = '0; dtr[c] = '0; atr[c] = '0; btr[c] = '0;
    end
    for (int c = 1; c <= n; c++) begin
      pdo_ready = !(c >= st_lo && c <= st_hi);
      start = (c == restart_at);
      rst = (c == rst_at);
      @(negedge clk);
      tr[c] = {|decrypt, sdi_ready, zrst, pdo_valid, pdi_ready, busy, done, correct_cnt,
               senc, sen & ~senc, yrst, xrst, srst};
      ctr[c] = constant; dtr[c] = domain; atr[c] = act_vec;
      btr[c] = {b_done, b_correct_cnt, b_decrypt == 8'hFF, |b_decrypt};
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0; pdo_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; b_start = 1'b0;
    {op_incr, op_dec, op_emit, op_msg, op_tweak, op_key, op_clr} = 7'd0;
    domain_i = 8'h00; sdi_valid = 1'b1; pdi_valid = 1'b1; pdo_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_outputs", act_vec, 0);
    @(posedge clk); #1;

    // All phases, 32-bit bus.
    issue(7'b1111111, 8'h5A, 1'b0);
    capture(70, 0, 0, 0, 0);
    check("clr_cycle", first(0), 1);
    check("clr_count", cnt(0, 1, 127), 1);
    check("zrst_cycle", first(10), 1);
    check("xrst_2_5", cnt(1, 2, 5), 4);
    check("xrst_total", cnt(1, 1, 127), 4);
    check("yrst_6_9", cnt(2, 6, 9), 4);
    check("yrst_total", cnt(2, 1, 127), 4);
    check("msg_sen_10_13", cnt(3, 10, 13), 4);
    check("msg_sen_total", cnt(3, 1, 127), 4);
    check("senc_14_53", cnt(4, 14, 53), 40);
    check("senc_total", cnt(4, 1, 127), 40);
    check("corr_cnt_54", cnt(5, 54, 54), 1);
    check("corr_cnt_total", cnt(5, 1, 127), 1);
    check("done_cycle", first(6), 55);
    check("done_count", cnt(6, 1, 127), 1);
    check("busy_1_55", cnt(7, 1, 55), 55);
    check("busy_total", cnt(7, 1, 127), 55);
    check("decrypt_msg_only", cnt(12, 1, 127), 4);
    check("rc_round0", ctr[14], 12'h001);
    check("rc_round1", ctr[15], 12'h003);
    check("rc_round2", ctr[16], 12'h007);
    check("rc_round3", ctr[17], 12'h00F);
    check("rc_round4", ctr[18], 12'h01F);
    check("rc_round5", ctr[19], 12'h03E);
    check("rc_before_tbc", ctr[13], 12'h000);

    // Emit with a 3-cycle output stall after two words.
    issue(7'b0011000, 8'h11, 1'b0);
    capture(60, 3, 5, 0, 0);
    check("stall_sen_pulses", cnt(3, 1, 60), 4);
    check("stall_pdi_ready", cnt(8, 3, 5), 0);
    check("stall_sen", cnt(3, 3, 5), 0);
    check("stall_pdo_valid", cnt(9, 1, 7), 7);
    check("stall_done_cycle", first(6), 49);

    // Message only, domain latch, start during TBC ignored.
    issue(7'b0001000, 8'h2C, 1'b0);
    capture(100, 0, 0, 20, 0);
    check("msgonly_no_setup", cnt(0, 1, 127) + cnt(1, 1, 127) + cnt(2, 1, 127), 0);
    check("domain_after_start", dtr[1], 8'h2C);
    check("domain_held", dtr[100], 8'h2C);
    check("msgonly_done_cycle", first(6), 46);
    check("msgonly_done_count", cnt(6, 1, 100), 1);
    check("msgonly_busy", cnt(7, 1, 100), 46);

    // Reset during TBC round 10 (no setup phases: round r is cycle r+1).
    issue(7'b0000000, 8'h77, 1'b0);
    capture(80, 0, 0, 0, 11);
    check("rc_round10", ctr[11], 12'h01E);
    check("after_rst_outputs", atr[12], 0);
    check("after_rst_busy", cnt(7, 12, 80), 0);
    check("after_rst_no_done", cnt(6, 1, 80), 0);
    issue(7'b0000000, 8'h01, 1'b0);
    capture(45, 0, 0, 0, 0);
    check("restart_rc0", ctr[1], 12'h001);
    check("restart_done", first(6), 42);

    // 64-bit bus: two message words, decrypt on all eight bytes.
    issue(7'b1101000, 8'h00, 1'b1);
    capture(50, 0, 0, 0, 0);
    check("dec64_word0", btr[1][1], 1);
    check("dec64_word1", btr[2][1], 1);
    check("dec64_count", bcnt(0), 2);
    check("incr64_corr", btr[43][2], 1);
    check("incr64_count", bcnt(2), 1);
    check("done64_cycle", btr[44][3], 1);

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 3000; c++) begin
      sdi_valid = ($urandom % 4) != 0;
      pdi_valid = ($urandom % 4) != 0;
      pdo_ready = ($urandom % 3) != 0;
      start = ($urandom % 6) == 0;
      {op_incr, op_dec, op_emit, op_msg, op_tweak, op_key, op_clr} = 7'($urandom);
      domain_i = 8'($urandom);
      rst = ($urandom % 700) == 0;
      @(posedge clk); #1;
    end
    start = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
